// File: rtl/serial_frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
// Frame layout: start, DATA_W data bits LSB-first, parity, stop.
package serial_rx_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } rx_state_t;

    // Default geometry for an 8-bit payload
    localparam int DATA_W_DFLT = 8;
    localparam int FRAME_W     = DATA_W_DFLT + 3;
    localparam int PAR_IDX     = DATA_W_DFLT;
    localparam int STOP_IDX    = DATA_W_DFLT + 1;

    // Position of the parity bit among the bits after start
    function automatic int par_idx(input int dw);
        return dw;
    endfunction

    // Position of the stop bit among the bits after start
    function automatic int stop_idx(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/serial_frame_rx_sipo.sv
// Serial-in/parallel-out shift register, new bit enters at the MSB.
// o_next exposes the word as it will look after the current shift.
module rx_shift_sipo #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_next
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_next;

    assign w_next = {i_bit, r_q[W-1:1]};
    assign o_q    = r_q;
    assign o_next = w_next;

    // Clear has priority; otherwise shift right on enable
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: framing/parity checks, valid/ready output,
// one-cycle error pulses.
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic              sin,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int SR_W  = DATA_W + 2;
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam int P_IDX = par_idx(DATA_W);
    localparam int S_IDX = stop_idx(DATA_W);
    localparam logic [CNT_W-1:0] STOP_CNT = CNT_W'(S_IDX);

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_perr;
    logic              r_ferr;
    logic              r_ovr;

    logic              w_start;
    logic              w_take;
    logic              w_shift;
    logic              w_clr;
    logic              w_last;
    logic              w_stop;
    logic              w_par_ok;
    logic [SR_W-1:0]   w_sr_q;
    logic [SR_W-1:0]   w_frame;

    // A start bit is only taken when no unread byte would be lost
    assign w_start = sample_en && !sin;
    assign w_take  = w_start &&
                     ((r_state == IDLE) ||
                      ((r_state == HOLD) && ready));
    assign w_shift = sample_en && (r_state == RECV);
    assign w_clr   = reset || w_take;
    assign w_last  = (r_cnt == STOP_CNT);

    rx_shift_sipo #(
        .W (SR_W)
    ) u_sipo (
        .clk    (clk),
        .i_clr  (w_clr),
        .i_en   (w_shift),
        .i_bit  (sin),
        .o_q    (w_sr_q),
        .o_next (w_frame)
    );

    // The stop bit is judged in its own strobe cycle, so look at the
    // shifted-in view of the frame rather than the stored one.
    assign w_stop   = w_frame[S_IDX];
    assign w_par_ok = ((^w_frame[DATA_W-1:0]) ^ w_frame[P_IDX])
                      == PARITY_ODD;

    assign data       = r_data;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;

    // Receiver FSM with registered outputs and error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_state <= RECV;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RECV: begin
                    if (sample_en) begin
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            if (!w_stop) begin
                                r_ferr  <= 1'b1;
                                r_state <= IDLE;
                            end else if (!w_par_ok) begin
                                r_perr  <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_data  <= w_frame[DATA_W-1:0];
                                r_valid <= 1'b1;
                                r_state <= HOLD;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (ready) begin
                        r_valid <= 1'b0;
                        if (w_take) begin
                            r_state <= RECV;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_start) begin
                        r_ovr <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized scoreboard bench for serial_frame_rx.
// Stimulus pushes expected events; a monitor pops and compares.
`timescale 1ns/1ps
module tb_serial_frame_rx;

    localparam int EV_DAT = 0;
    localparam int EV_PAR = 1;
    localparam int EV_FRM = 2;
    localparam int EV_OVR = 3;

    typedef struct {
        int         kind;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic       sin;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t q[$];

    serial_frame_rx #(
        .DATA_W     (8),
        .PARITY_ODD (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .sin        (sin),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d,
                             input int at);
        ev_t e;
        e.kind = kind;
        e.d    = d;
        e.cyc  = at;
        q.push_back(e);
    endtask

    // One bit strobe, then a random gap with line noise
    task automatic strobe(input logic b);
        sample_en = 1'b1;
        sin       = b;
        @(posedge clk); #1;
        sample_en = 1'b0;
        sin       = 1'($urandom);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            sin = 1'($urandom);
        end
    endtask

    // mode 0: normal, 1: dropped while a byte is unread (ready=0),
    // 2: normal with ready raised on the start strobe
    task automatic send_frame(input logic [7:0] d, input bit par_ok,
                              input bit stop_ok, input int mode,
                              input int nbits);
        logic [10:0] line;
        logic        pbit;
        int          k;
        pbit = ~(^d);
        if (!par_ok) pbit = ~pbit;
        line = {stop_ok, pbit, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (mode == 2 && i == 0) ready = 1'b1;
            if (mode == 1 && line[i] == 1'b0)
                expect_ev(EV_OVR, 8'h00, cyc + 1);
            if (mode != 1 && i == 10) begin
                if (!stop_ok)     k = EV_FRM;
                else if (!par_ok) k = EV_PAR;
                else              k = EV_DAT;
                expect_ev(k, d, cyc + 1);
            end
            strobe(line[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic take(input int kind);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d data=%0h",
                     kind, cyc, data);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                (kind == EV_DAT && e.d !== data)) begin
                errors++;
                $display("FAIL event act kind=%0d cyc=%0d data=%0h exp kind=%0d cyc=%0d data=%0h",
                         kind, cyc, data, e.kind, e.cyc, e.d);
            end
        end
    endtask

    // Monitor: matches every output event against the scoreboard
    initial begin : monitor
        logic       pv;
        logic       pr;
        logic [7:0] held;
        pv   = 1'b0;
        pr   = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_event act=none exp kind=%0d cyc=%0d",
                             q[0].kind, q[0].cyc);
                    void'(q.pop_front());
                end
                if (frame_err)  take(EV_FRM);
                if (parity_err) take(EV_PAR);
                if (overrun)    take(EV_OVR);
                if (valid && !pv) begin
                    take(EV_DAT);
                    held = data;
                end else if (valid && pv) begin
                    chk("data_stable", 32'(data), 32'(held));
                end
                if (pv && pr) chk("hs_clears_valid", 32'(valid), 0);
                if (pv && !pr) chk("valid_held", 32'(valid), 1);
            end
            pv = valid & ~reset;
            pr = ready;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset     = 1'b1;
        sample_en = 1'b0;
        sin       = 1'b1;
        ready     = 1'b1;
        idle(3);
        reset = 1'b0;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_errs", 32'({parity_err, frame_err, overrun}), 0);

        send_frame(8'hA5, 1'b1, 1'b1, 0, 11);
        idle(3);
        chk("a5_busy_after", 32'(busy), 0);
        chk("a5_data_kept", 32'(data), 32'hA5);

        send_frame(8'hA5, 1'b0, 1'b1, 0, 11);
        idle(2);
        chk("perr_busy", 32'(busy), 0);
        chk("perr_valid", 32'(valid), 0);

        send_frame(8'h3C, 1'b1, 1'b0, 0, 11);
        send_frame(8'h3C, 1'b0, 1'b0, 0, 11);
        idle(2);
        chk("ferr_valid", 32'(valid), 0);

        ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 0, 11);
        send_frame(8'h3C, 1'b1, 1'b1, 1, 11);
        idle(2);
        chk("ovr_valid", 32'(valid), 1);
        chk("ovr_data", 32'(data), 32'hA5);
        ready = 1'b1;
        idle(2);
        chk("ovr_release", 32'(valid), 0);

        ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 0, 11);
        idle(2);
        send_frame(8'h3C, 1'b1, 1'b1, 2, 11);
        idle(3);
        chk("b2b_data", 32'(data), 32'h3C);

        send_frame(8'h3C, 1'b1, 1'b1, 0, 5);
        chk("mid_busy", 32'(busy), 1);
        reset     = 1'b1;
        sample_en = 1'b0;
        sin       = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_data", 32'(data), 0);
        chk("mid_rst_errs", 32'({parity_err, frame_err, overrun}), 0);
        sin = 1'b0;
        idle(3);
        chk("sin_ignored", 32'(busy), 0);
        sin = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 0, 11);

        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom),
                       $urandom_range(0, 4) != 0,
                       $urandom_range(0, 4) != 0, 0, 11);
            repeat ($urandom_range(0, 2)) strobe(1'b1);
        end

        idle(5);
        chk("queue_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Receives 11-bit serial frames (start, 8 data LSB-first, odd parity, stop), one bit per sample strobe. It checks the framing, presents the data byte on a valid/ready handshake and reports errors as one-cycle pulses. It sits downstream of the frame shift register and consumes its serial output (sout, MSB-first frame emission; idle line = 1). It feeds the byte-level consumer logic (command decode / display).

Parameters:
DATA_W, 8, data bits per frame; frame length = DATA_W+3
PARITY_ODD, 1, 1 = odd parity, 0 = even parity

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
sample_en  input  1  bit strobe; exactly one cycle per bit period; sin is sampled only when high
sin  input  1  serial line; idle = 1
data  output  DATA_W  received byte, stable while valid
valid  output  1  data holds an accepted, error-free byte
ready  input  1  consumer accepts data when valid&&ready
busy  output  1  frame reception in progress (state RECV)
parity_err  output  1  one-cycle pulse, parity mismatch
frame_err  output  1  one-cycle pulse, stop bit sampled 0
overrun  output  1  one-cycle pulse, start bit seen while holding unread byte

Behaviour:
- Clock clk; reset synchronous, active-high, named reset. Reset forces IDLE, data=0, valid=0, busy=0, all error pulses 0, bit counter=0, shift contents=0. Reset mid-frame discards the partial frame.
- All sampling is gated by sample_en. sin changes without sample_en are ignored.
- States: IDLE, RECV, HOLD.
- IDLE: sample_en && sin==0 -> RECV, counter=0 (start bit consumed). sample_en && sin==1 -> stay.
- RECV: each sample_en shifts sin into the register (LSB-first assembly: new bit enters at MSB and shifts right) and increments the counter. Bits 0..DATA_W-1 are data, bit DATA_W is parity, bit DATA_W+1 is stop.
- On the sample_en of the stop bit, evaluate the frame in that same cycle:
  - Stop==0: frame_err=1 next cycle -> IDLE, valid stays 0. Frame error takes priority over parity error; at most one error pulse per frame.
  - Parity check: XOR(data bits, parity bit) must be 1 when PARITY_ODD=1 and 0 otherwise. On mismatch: parity_err=1 next cycle -> IDLE.
  - Otherwise: data is loaded and valid=1 on the next cycle -> HOLD. Latency from the stop-bit strobe to valid is 1 clk.
- HOLD: valid=1, data is frozen.
  - ready=1 -> valid=0 next cycle. If the same cycle also has sample_en && sin==0, go to RECV (start accepted, no overrun); otherwise go to IDLE.
  - ready=0 && sample_en && sin==0: overrun=1 for one cycle; the new frame is dropped, the held data is unchanged, and the state stays HOLD. The remaining bits of the dropped frame may produce further overrun pulses only on 0-bits. This is accepted.
- busy=1 exactly in RECV. Error pulses last exactly 1 clk.
- data persists after the handshake until the next successful frame overwrites it.
- Counter width is clog2(DATA_W+2). No wrap-around within a frame: RECV always exits on the stop bit.

Decomposition:
- Package serial_rx_pkg: state enum (IDLE, RECV, HOLD), FRAME_W = DATA_W+3 and stop/parity bit-index constants.
- Sub-module rx_shift_sipo: serial-in/parallel-out register with shift enable and clear, width DATA_W+2.
- The top holds the FSM, counter, checks and handshake.

Test Plan:
- Frame 0xA5 (line: 0, 1,0,1,0,0,1,0,1, parity 1, stop 1) with ready=1 -> data=0xA5, valid high 1 clk after the stop strobe, cleared the cycle after the handshake, no errors.
- Same frame with parity bit 0 -> parity_err single pulse, valid never asserts, state returns to IDLE, busy=0.
- Frame 0x3C with stop bit 0 -> frame_err single pulse only (no parity_err), valid=0.
- 0xA5 received with ready=0, then a start bit for 0x3C -> overrun pulse, data stays 0xA5, valid stays 1. Raising ready then clears valid.
- 0xA5 held; ready=1 in the same cycle as the start-bit strobe of 0x3C -> no overrun, 0x3C received, valid re-asserts with data=0x3C.
- Reset asserted after 4 data bits -> busy=0 and all outputs 0 next cycle. A following full 0x3C frame is received correctly; sin pulled low without sample_en is ignored.
